// File: rtl/cache_pkg.sv
// cache_pkg: shared types and helpers for the 2-way set-associative data cache.
//   state_t  - miss-handling FSM states
//   tag_w / block_w / maddr_w - derived width helpers
//   NUM_WAYS, WAY0, WAY1 - way-index constants
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        FETCH     = 2'd2,
        REFILL    = 2'd3
    } state_t;

    localparam int NUM_WAYS = 2;
    localparam int WAY0     = 0;
    localparam int WAY1     = 1;

    function automatic int tag_w(input int addr_w, input int index_w, input int offset_w);
        return addr_w - index_w - offset_w;
    endfunction

    function automatic int block_w(input int word_w, input int offset_w);
        return word_w << offset_w;
    endfunction

    function automatic int maddr_w(input int tag_width, input int index_w);
        return tag_width + index_w;
    endfunction

endpackage

// File: rtl/cache_way.sv
// cache_way: one way of the cache - per-set valid/dirty/tag/block storage,
// tag compare, word-select mux, CPU word write and block refill.
//   index/offset/tag  - lookup address fields (current CPU request)
//   hit, word         - lookup result and selected word
//   line_*            - state of the set addressed by index (victim info)
//   word_we, wdata    - CPU store into the word at {index, offset}
//   fill_*            - whole-block refill; leaves the line valid and clean
module cache_way
    import cache_pkg::*;
#(
    parameter int WORD_W   = 8,
    parameter int OFFSET_W = 2,
    parameter int INDEX_W  = 2,
    parameter int TAG_W    = 4,
    localparam int BLOCK_W = block_w(WORD_W, OFFSET_W),
    localparam int SETS    = 1 << INDEX_W,
    localparam int WORDS   = 1 << OFFSET_W
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [INDEX_W-1:0]  index,
    input  logic [OFFSET_W-1:0] offset,
    input  logic [TAG_W-1:0]    tag,
    output logic                hit,
    output logic [WORD_W-1:0]   word,
    output logic                line_valid,
    output logic                line_dirty,
    output logic [TAG_W-1:0]    line_tag,
    output logic [BLOCK_W-1:0]  line_data,
    input  logic                word_we,
    input  logic [WORD_W-1:0]   wdata,
    input  logic                fill_we,
    input  logic [INDEX_W-1:0]  fill_index,
    input  logic [TAG_W-1:0]    fill_tag,
    input  logic [BLOCK_W-1:0]  fill_data
);

    logic [SETS-1:0]                        valid_q;
    logic [SETS-1:0]                        dirty_q;
    logic [SETS-1:0][TAG_W-1:0]             tag_q;
    logic [SETS-1:0][WORDS-1:0][WORD_W-1:0] data_q;

    assign line_valid = valid_q[index];
    assign line_dirty = dirty_q[index];
    assign line_tag   = tag_q[index];
    assign line_data  = data_q[index];
    assign hit        = valid_q[index] && (tag_q[index] == tag);
    assign word       = data_q[index][offset];

    // fill and CPU write never coincide: fill happens only in REFILL,
    // CPU writes only on an IDLE hit
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
            dirty_q <= '0;
            tag_q   <= '0;
            data_q  <= '0;
        end else if (fill_we) begin
            valid_q[fill_index] <= 1'b1;
            dirty_q[fill_index] <= 1'b0;
            tag_q[fill_index]   <= fill_tag;
            data_q[fill_index]  <= fill_data;
        end else if (word_we) begin
            data_q[index][offset] <= wdata;
            dirty_q[index]        <= 1'b1;
        end
    end

endmodule

// File: rtl/assoc_data_cache.sv
// assoc_data_cache: 2-way set-associative, write-back, write-allocate data cache.
//   CPU side: read/write/address/writedata in, readdata/busywait out.
//     Hits complete with no stall; misses hold busywait until refill is done.
//   Memory side: block-wide mem_read/mem_write/mem_address/mem_writedata out,
//     mem_readdata/mem_busywait in. All memory-side outputs are registered.
//   Holds the per-set LRU bit, victim selection and the miss FSM.
module assoc_data_cache
    import cache_pkg::*;
#(
    parameter int ADDR_W   = 8,
    parameter int WORD_W   = 8,
    parameter int OFFSET_W = 2,
    parameter int INDEX_W  = 2,
    localparam int TAG_W   = tag_w(ADDR_W, INDEX_W, OFFSET_W),
    localparam int BLOCK_W = block_w(WORD_W, OFFSET_W),
    localparam int MADDR_W = maddr_w(TAG_W, INDEX_W),
    localparam int SETS    = 1 << INDEX_W
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               read,
    input  logic               write,
    input  logic [ADDR_W-1:0]  address,
    input  logic [WORD_W-1:0]  writedata,
    output logic [WORD_W-1:0]  readdata,
    output logic               busywait,
    input  logic               mem_busywait,
    input  logic [BLOCK_W-1:0] mem_readdata,
    output logic               mem_read,
    output logic               mem_write,
    output logic [MADDR_W-1:0] mem_address,
    output logic [BLOCK_W-1:0] mem_writedata
);

    logic [TAG_W-1:0]    tag;
    logic [INDEX_W-1:0]  index;
    logic [OFFSET_W-1:0] offset;
    assign {tag, index, offset} = address;

    logic [NUM_WAYS-1:0]              way_hit, way_valid, way_dirty, way_we, way_fill;
    logic [NUM_WAYS-1:0][WORD_W-1:0]  way_word;
    logic [NUM_WAYS-1:0][TAG_W-1:0]   way_tag;
    logic [NUM_WAYS-1:0][BLOCK_W-1:0] way_data;

    state_t              state_q, state_n;
    logic [SETS-1:0]     lru_q;
    logic                victim, victim_q;
    logic [TAG_W-1:0]    miss_tag_q;
    logic [INDEX_W-1:0]  miss_index_q;
    logic [BLOCK_W-1:0]  fill_q;
    logic                first_q, first_n;
    logic                mem_read_n, mem_write_n;
    logic [MADDR_W-1:0]  mem_address_n;
    logic [BLOCK_W-1:0]  mem_writedata_n;

    logic req, hit, hit_access, miss_start, done, victim_dirty;

    assign req        = read | write;
    assign hit        = |way_hit;
    assign hit_access = (state_q == IDLE) && req && hit;
    assign miss_start = (state_q == IDLE) && req && !hit;
    // the request's first cycle never completes, whatever mem_busywait shows
    assign done       = !first_q && !mem_busywait;

    // gated by reset so the stall drops the instant reset asserts
    assign busywait = reset && req && ((state_q != IDLE) || !hit);
    assign readdata = way_hit[WAY1] ? way_word[WAY1] :
                      way_hit[WAY0] ? way_word[WAY0] : '0;

    for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
        assign way_we[w]   = hit_access && write && way_hit[w];
        assign way_fill[w] = (state_q == REFILL) && (victim_q == 1'(w));

        cache_way #(
            .WORD_W   (WORD_W),
            .OFFSET_W (OFFSET_W),
            .INDEX_W  (INDEX_W),
            .TAG_W    (TAG_W)
        ) u_way (
            .clock      (clock),
            .reset      (reset),
            .index      (index),
            .offset     (offset),
            .tag        (tag),
            .hit        (way_hit[w]),
            .word       (way_word[w]),
            .line_valid (way_valid[w]),
            .line_dirty (way_dirty[w]),
            .line_tag   (way_tag[w]),
            .line_data  (way_data[w]),
            .word_we    (way_we[w]),
            .wdata      (writedata),
            .fill_we    (way_fill[w]),
            .fill_index (miss_index_q),
            .fill_tag   (miss_tag_q),
            .fill_data  (fill_q)
        );
    end

    // first invalid way (way0 preferred), else the LRU way
    always_comb begin
        victim = lru_q[index];
        if (!way_valid[WAY0])      victim = 1'b0;
        else if (!way_valid[WAY1]) victim = 1'b1;
    end
    assign victim_dirty = way_valid[victim] && way_dirty[victim];

    always_comb begin
        state_n         = state_q;
        mem_read_n      = mem_read;
        mem_write_n     = mem_write;
        mem_address_n   = mem_address;
        mem_writedata_n = mem_writedata;
        first_n         = 1'b0;
        case (state_q)
            IDLE: begin
                if (miss_start) begin
                    first_n = 1'b1;
                    if (victim_dirty) begin
                        state_n         = WRITEBACK;
                        mem_write_n     = 1'b1;
                        mem_address_n   = {way_tag[victim], index};
                        mem_writedata_n = way_data[victim];
                    end else begin
                        state_n       = FETCH;
                        mem_read_n    = 1'b1;
                        mem_address_n = {tag, index};
                    end
                end
            end
            WRITEBACK: begin
                if (done) begin
                    state_n       = FETCH;
                    mem_write_n   = 1'b0;
                    mem_read_n    = 1'b1;
                    mem_address_n = {miss_tag_q, miss_index_q};
                    first_n       = 1'b1;
                end
            end
            FETCH: begin
                if (done) begin
                    state_n    = REFILL;
                    mem_read_n = 1'b0;
                end
            end
            REFILL:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            mem_read      <= 1'b0;
            mem_write     <= 1'b0;
            mem_address   <= '0;
            mem_writedata <= '0;
            first_q       <= 1'b0;
            lru_q         <= '0;
            victim_q      <= 1'b0;
            miss_tag_q    <= '0;
            miss_index_q  <= '0;
            fill_q        <= '0;
        end else begin
            state_q       <= state_n;
            mem_read      <= mem_read_n;
            mem_write     <= mem_write_n;
            mem_address   <= mem_address_n;
            mem_writedata <= mem_writedata_n;
            first_q       <= first_n;
            // miss address is latched so a dropped request still refills correctly
            if (miss_start) begin
                victim_q     <= victim;
                miss_tag_q   <= tag;
                miss_index_q <= index;
            end
            if ((state_q == FETCH) && done) fill_q <= mem_readdata;
            // the touched way becomes MRU, so lru names the other one
            if (hit_access) lru_q[index] <= !way_hit[WAY1];
        end
    end

endmodule

// File: tb/tb_assoc_data_cache.sv
module tb_assoc_data_cache;

    localparam int LAT = 2;

    logic        clock, reset, read, write;
    logic [7:0]  address, writedata, readdata;
    logic        busywait, mem_busywait, mem_read, mem_write;
    logic [31:0] mem_readdata, mem_writedata;
    logic [5:0]  mem_address;

    assoc_data_cache dut (
        .clock         (clock),
        .reset         (reset),
        .read          (read),
        .write         (write),
        .address       (address),
        .writedata     (writedata),
        .readdata      (readdata),
        .busywait      (busywait),
        .mem_busywait  (mem_busywait),
        .mem_readdata  (mem_readdata),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_address   (mem_address),
        .mem_writedata (mem_writedata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // memory model: busy from the request's first cycle for LAT cycles
    logic [31:0] mem [64];
    logic [1:0]  op, op_q;
    int          cnt;
    logic        log_wr   [32];
    logic [5:0]  log_addr [32];
    logic [31:0] log_data [32];
    int          log_total;

    assign op           = {mem_read, mem_write};
    assign mem_busywait = (op != 2'b00) && ((op != op_q) || (cnt < LAT));
    assign mem_readdata = mem[mem_address];

    initial begin
        op_q      = 2'b00;
        cnt       = 0;
        log_total = 0;
        for (int i = 0; i < 64; i++) mem[i] = 32'hD0C0B000 + 32'(i);
        mem[0] = 32'h44332211;
    end

    always @(posedge clock) begin
        if ((op != 2'b00) && (op != op_q) && (log_total < 32)) begin
            log_wr[log_total]   <= mem_write;
            log_addr[log_total] <= mem_address;
            log_data[log_total] <= mem_writedata;
            log_total           <= log_total + 1;
        end
        if (mem_write && !mem_busywait) mem[mem_address] <= mem_writedata;
        if (op == 2'b00)     cnt <= 0;
        else if (op != op_q) cnt <= 1;
        else                 cnt <= cnt + 1;
        op_q <= op;
    end

    int n_cmp = 0;
    int n_bad = 0;

    // drive one CPU access at a negedge, count stalled cycles, sample readdata
    task automatic access(input logic rd, input logic wr, input logic [7:0] addr,
                          input logic [7:0] wd, output int stall, output logic [7:0] rdata);
        @(negedge clock);
        read = rd; write = wr; address = addr; writedata = wd;
        #1;
        stall = 0;
        while (busywait && stall < 100) begin
            @(negedge clock); #1;
            stall++;
        end
        rdata = readdata;
        if (stall >= 100) begin
            n_cmp++; n_bad++;
            $display("FAIL access_timeout addr=%h", addr);
        end
        @(posedge clock); #1;
        read = 1'b0; write = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; read = 1'b0; write = 1'b0; address = '0; writedata = '0;
        #1 reset = 1'b0;
        repeat (2) @(negedge clock);
        n_cmp++; if (busywait !== 1'b0) begin n_bad++; $display("FAIL rst_busywait got=%b want=0", busywait); end
        n_cmp++; if (readdata !== 8'h00) begin n_bad++; $display("FAIL rst_readdata got=%h want=00", readdata); end
        n_cmp++; if ({mem_read, mem_write} !== 2'b00) begin n_bad++; $display("FAIL rst_mem_rw got=%b want=00", {mem_read, mem_write}); end
        n_cmp++; if (mem_address !== 6'h00 || mem_writedata !== 32'h0) begin
            n_bad++; $display("FAIL rst_mem_bus got=%h/%h want=00/0", mem_address, mem_writedata);
        end
        reset = 1'b1;
    endtask

    task automatic test_read_miss();
        int s; logic [7:0] d; int b;
        b = log_total;
        access(1'b1, 1'b0, 8'h01, 8'h00, s, d);
        n_cmp++; if (s !== 5) begin n_bad++; $display("FAIL rmiss_stall got=%0d want=5", s); end
        n_cmp++; if (d !== 8'h22) begin n_bad++; $display("FAIL rmiss_data got=%h want=22", d); end
        n_cmp++; if (log_total !== b + 1 || log_wr[b] !== 1'b0 || log_addr[b] !== 6'h00) begin
            n_bad++; $display("FAIL rmiss_fetch got n=%0d wr=%b addr=%h want n=%0d wr=0 addr=00", log_total - b, log_wr[b], log_addr[b], 1);
        end
        access(1'b1, 1'b0, 8'h03, 8'h00, s, d);
        n_cmp++; if (s !== 0) begin n_bad++; $display("FAIL rhit_stall got=%0d want=0", s); end
        n_cmp++; if (d !== 8'h44) begin n_bad++; $display("FAIL rhit_data got=%h want=44", d); end
    endtask

    task automatic test_write_miss();
        int s; logic [7:0] d; int b;
        b = log_total;
        access(1'b0, 1'b1, 8'h40, 8'hAA, s, d);
        n_cmp++; if (s !== 5) begin n_bad++; $display("FAIL wmiss_stall got=%0d want=5", s); end
        n_cmp++; if (log_total !== b + 1 || log_wr[b] !== 1'b0 || log_addr[b] !== 6'h10) begin
            n_bad++; $display("FAIL wmiss_fetch got wr=%b addr=%h want wr=0 addr=10", log_wr[b], log_addr[b]);
        end
        access(1'b1, 1'b0, 8'h40, 8'h00, s, d);
        n_cmp++; if (s !== 0 || d !== 8'hAA) begin n_bad++; $display("FAIL wmiss_readback got=%0d/%h want=0/aa", s, d); end
        access(1'b1, 1'b0, 8'h41, 8'h00, s, d);
        n_cmp++; if (s !== 0 || d !== 8'hB0) begin n_bad++; $display("FAIL wmiss_word1 got=%0d/%h want=0/b0", s, d); end
    endtask

    task automatic test_clean_replace();
        int s; logic [7:0] d; int b;
        b = log_total;
        access(1'b1, 1'b0, 8'h80, 8'h00, s, d);
        n_cmp++; if (s !== 5) begin n_bad++; $display("FAIL clean_stall got=%0d want=5", s); end
        n_cmp++; if (log_total !== b + 1 || log_wr[b] !== 1'b0 || log_addr[b] !== 6'h20) begin
            n_bad++; $display("FAIL clean_fetch got n=%0d wr=%b addr=%h want n=1 wr=0 addr=20", log_total - b, log_wr[b], log_addr[b]);
        end
        n_cmp++; if (d !== 8'h20) begin n_bad++; $display("FAIL clean_data got=%h want=20", d); end
    endtask

    task automatic test_dirty_writeback();
        int s; logic [7:0] d; int b;
        b = log_total;
        access(1'b1, 1'b0, 8'hC0, 8'h00, s, d);
        n_cmp++; if (s !== 8) begin n_bad++; $display("FAIL dirty_stall got=%0d want=8", s); end
        n_cmp++; if (log_total !== b + 2 || log_wr[b] !== 1'b1 || log_addr[b] !== 6'h10 || log_data[b][7:0] !== 8'hAA) begin
            n_bad++; $display("FAIL dirty_wb got n=%0d wr=%b addr=%h data=%h want n=2 wr=1 addr=10 data=..aa", log_total - b, log_wr[b], log_addr[b], log_data[b]);
        end
        n_cmp++; if (log_wr[b+1] !== 1'b0 || log_addr[b+1] !== 6'h30) begin
            n_bad++; $display("FAIL dirty_fetch got wr=%b addr=%h want wr=0 addr=30", log_wr[b+1], log_addr[b+1]);
        end
        n_cmp++; if (mem[16] !== 32'hD0C0B0AA) begin n_bad++; $display("FAIL dirty_memimg got=%h want=d0c0b0aa", mem[16]); end
        n_cmp++; if (d !== 8'h30) begin n_bad++; $display("FAIL dirty_data got=%h want=30", d); end
    endtask

    task automatic test_reset_mid_fetch();
        int s; logic [7:0] d; int b; int n;
        @(negedge clock);
        read = 1'b1; address = 8'h40;
        n = 0;
        while (!mem_read && n < 20) begin @(negedge clock); n++; end
        n_cmp++; if (mem_read !== 1'b1) begin n_bad++; $display("FAIL midrst_fetch_seen got=%b want=1", mem_read); end
        #2 reset = 1'b0;
        #1;
        n_cmp++; if (mem_read !== 1'b0) begin n_bad++; $display("FAIL midrst_mem_read got=%b want=0", mem_read); end
        n_cmp++; if (busywait !== 1'b0) begin n_bad++; $display("FAIL midrst_busywait got=%b want=0", busywait); end
        @(negedge clock); read = 1'b0;
        @(negedge clock); reset = 1'b1;
        b = log_total;
        access(1'b1, 1'b0, 8'h40, 8'h00, s, d);
        n_cmp++; if (s !== 5) begin n_bad++; $display("FAIL midrst_remiss got=%0d want=5", s); end
        n_cmp++; if (log_addr[b] !== 6'h10 || d !== 8'hAA) begin
            n_bad++; $display("FAIL midrst_refill got addr=%h data=%h want addr=10 data=aa", log_addr[b], d);
        end
    endtask

    task automatic test_read_write_together();
        int s; logic [7:0] d; int b;
        access(1'b1, 1'b0, 8'h01, 8'h00, s, d);
        n_cmp++; if (s !== 5 || d !== 8'h22) begin n_bad++; $display("FAIL rw_prefill got=%0d/%h want=5/22", s, d); end
        access(1'b1, 1'b1, 8'h01, 8'h5C, s, d);
        n_cmp++; if (s !== 0) begin n_bad++; $display("FAIL rw_stall got=%0d want=0", s); end
        access(1'b1, 1'b0, 8'h01, 8'h00, s, d);
        n_cmp++; if (d !== 8'h5C) begin n_bad++; $display("FAIL rw_written got=%h want=5c", d); end
        access(1'b1, 1'b0, 8'h81, 8'h00, s, d);
        n_cmp++; if (s !== 5) begin n_bad++; $display("FAIL rw_clean_evict got=%0d want=5", s); end
        b = log_total;
        access(1'b1, 1'b0, 8'hC1, 8'h00, s, d);
        n_cmp++; if (s !== 8 || log_wr[b] !== 1'b1 || log_addr[b] !== 6'h00 || log_data[b] !== 32'h44335C11) begin
            n_bad++; $display("FAIL rw_dirty_wb got stall=%0d wr=%b addr=%h data=%h want 8/1/00/44335c11", s, log_wr[b], log_addr[b], log_data[b]);
        end
        n_cmp++; if (d !== 8'hB0) begin n_bad++; $display("FAIL rw_final_data got=%h want=b0", d); end
    endtask

    initial begin
        test_reset();
        test_read_miss();
        test_write_miss();
        test_clean_replace();
        test_dirty_writeback();
        test_reset_mid_fetch();
        test_read_write_together();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/assoc_data_cache.md
# assoc_data_cache

Parametrised 2-way set-associative, write-back, write-allocate data cache between the CPU load/store path and the block-wide data memory. It replaces the direct-mapped cache. It keeps the same CPU-side busywait handshake and the same memory-side read/write/busywait handshake, and adds per-set LRU replacement and a registered miss state machine. A read hit returns data combinationally with no stall. A miss stalls the CPU until the victim write-back (if dirty) and the block refill complete.

## Interface
- ADDR_W, 8, CPU byte-address width
- WORD_W, 8, CPU data word width
- OFFSET_W, 2, word-offset bits; block = 2**OFFSET_W words
- INDEX_W, 2, set-index bits; sets = 2**INDEX_W
- Derived values: TAG_W = ADDR_W-INDEX_W-OFFSET_W; BLOCK_W = WORD_W<<OFFSET_W; MADDR_W = TAG_W+INDEX_W
- Clock and reset (already decided): one clock, `clock`. Reset is `reset`, asynchronous and active-low.
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous active-low reset
- read  in  1  CPU read request, held until busywait low
- write  in  1  CPU write request, held until busywait low
- address  in  ADDR_W  {tag, index, offset}
- writedata  in  WORD_W  CPU store data
- readdata  out  WORD_W  selected word of the hit way
- busywait  out  1  CPU stall
- mem_busywait  in  1  memory busy
- mem_readdata  in  BLOCK_W  refill block
- mem_read  out  1  block read request
- mem_write  out  1  block write request
- mem_address  out  MADDR_W  block address {tag, index}
- mem_writedata  out  BLOCK_W  victim block

## Operation
- Per way and per set the cache holds valid, dirty, tag and a block. Per set it holds one lru bit, which names the least-recently-used way.
- A hit occurs when either way has valid=1 and its tag equals the request tag. A hit on both ways is impossible by construction.
- busywait = (read|write) & (state!=IDLE | !hit), computed combinationally.
- Read hit: readdata = word[offset] of the hit way, in the same cycle.
- Write hit: at the posedge, write the byte lane, set dirty=1, and set lru to the other way.
- A read hit also sets lru to the other way at the posedge.
- Victim selection: the first invalid way, preferring way0. If both ways are valid, the victim is way[lru]. The victim is latched on leaving IDLE.
- FSM states are IDLE, WRITEBACK, FETCH and REFILL.
  - IDLE: on a miss, go to WRITEBACK if the victim is valid and dirty, otherwise go to FETCH.
  - WRITEBACK: mem_write=1, mem_address={victim tag, index}, mem_writedata=victim block. On completion go to FETCH.
  - FETCH: mem_read=1, mem_address={request tag, index}. On completion go to REFILL.
  - REFILL: write mem_readdata (latched at completion) into the victim way with valid=1, dirty=0, tag=request tag, then return to IDLE. The access then hits in IDLE and follows the hit rules.
- Memory completion: the first posedge after the request's first cycle at which mem_busywait=0. The memory raises mem_busywait in the same cycle the request rises.
- read and write asserted together: write wins.
- Request dropped mid-miss: the miss sequence runs to IDLE anyway. No CPU write is performed.
- Assertion of reset, at any time including mid-miss: all valid, dirty, tag and lru bits, all data, and the state are cleared immediately. mem_read and mem_write drop immediately.
- Reset values: busywait 0, readdata 0, mem_read 0, mem_write 0, mem_address 0, mem_writedata 0.

## Timing
- Read hit: 0 stall cycles. Write hit: 0 stall cycles, array updated at the same posedge.
- Clean miss: 1 cycle to FETCH, plus the memory latency, plus 1 REFILL cycle, plus the hit cycle.
- Dirty miss: adds the WRITEBACK memory latency.
- mem_read and mem_write are registered outputs. They are never both high.
- mem_address and mem_writedata are stable for the whole request.

## Structure
- Package `cache_pkg` holds:
  - the state enum (IDLE, WRITEBACK, FETCH, REFILL)
  - width helper functions (TAG_W, BLOCK_W, MADDR_W)
  - way-index constants
- Sub-module `cache_way`: one way's valid/dirty/tag/data arrays, the tag compare, the word-select mux and the byte-lane write. It is instantiated twice.
- The top level holds the LRU bits, victim select and FSM.

## Test plan
All scenarios use default parameters: tag[7:4], index[3:2], offset[1:0].
- Reset, then read 0x01, memory returns 0x44332211 → FETCH with mem_address 0x00, then readdata 0x22. A following read of 0x03 returns 0x44 with busywait never high.
- Write 0x40 data 0xAA → clean miss, FETCH with mem_address 0x10, fill into way1, word0=0xAA, dirty set. A following read of 0x40 returns 0xAA with no stall.
- Read 0x80 (both ways valid, lru=way0, clean) → FETCH only with mem_address 0x20. way0 is replaced, lru becomes way1.
- Read 0xC0 → victim way1 is dirty → WRITEBACK with mem_address 0x10 and mem_writedata[7:0]=0xAA, then FETCH with mem_address 0x30.
- reset low during FETCH → mem_read drops in the same cycle, busywait 0. A following read of 0x40 misses.
- read and write high together at 0x01 on a hit → write is performed, dirty set, no stall.
